// File: rtl/microcontrolador_pwm_ctrl_pkg.sv
// Register map, CTRL/STATUS bit positions and the CTRL payload type shared by the PWM
// controller, its bench and the software header generator.
package microcontrolador_pwm_ctrl_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned STATUS_CNT_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_DUTY   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_IRQ_EN    = 1;
    localparam int unsigned CTRL_INV       = 2;
    localparam int unsigned STATUS_PEND    = 0;
    localparam int unsigned STATUS_RUNNING = 1;
    localparam int unsigned STATUS_CNT_LSB = 16;

    // Field order matches the CTRL bit indices above (en is the LSB).
    typedef struct packed {
        logic inv;
        logic irq_en;
        logic en;
    } ctrl_t;

    function automatic logic [DATA_W-1:0] ctrl_to_word(input ctrl_t c);
        return DATA_W'(c);
    endfunction

endpackage

// File: rtl/microcontrolador_pwm_core.sv
// PWM engine: period counter, double-buffered active period/duty, compare and output flop.
module microcontrolador_pwm_core #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             inv,
    input  logic [CNT_W-1:0] per_shadow,
    input  logic [CNT_W-1:0] duty_shadow,
    output logic [CNT_W-1:0] cnt,
    output logic             pwm_out,
    output logic             period_end_c
);

    logic [CNT_W-1:0] per_act;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] per_last;
    logic             per_zero;
    logic             wrap;
    logic             pwm_raw;

    // A zero period counts as "at the end" every cycle so the shadows keep reloading.
    assign per_zero     = (per_act == '0);
    assign per_last     = per_act - CNT_W'(1);
    assign wrap         = en & (per_zero | (cnt >= per_last));
    assign period_end_c = wrap & ~per_zero;
    assign pwm_raw      = en & ~per_zero & (cnt < duty_act);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            per_act  <= '0;
            duty_act <= '0;
            pwm_out  <= 1'b0;
        end else begin
            if (wrap || !en) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // Idle tracks the shadows; running only picks them up at the boundary.
            if (wrap || !en) begin
                per_act  <= per_shadow;
                duty_act <= duty_shadow;
            end
            pwm_out <= pwm_raw ^ inv;
        end
    end

endmodule

// File: rtl/microcontrolador_pwm_ctrl.sv
// Avalon-MM PWM controller: register file, pending/irq logic and read mux around the PWM core.
module microcontrolador_pwm_ctrl
    import microcontrolador_pwm_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              pwm_out,
    output logic              irq
);

    ctrl_t                    ctrl_q;
    logic [CNT_W-1:0]         per_shadow;
    logic [CNT_W-1:0]         duty_shadow;
    logic                     pend;
    logic [CNT_W-1:0]         cnt;
    logic                     period_end;
    logic                     wr_en;
    logic                     w1c_pend;
    logic [STATUS_CNT_W-1:0]  status_cnt;
    logic [DATA_W-1:0]        status_word;
    logic                     wdata_unused;

    assign wr_en        = chipselect & ~write_n;
    assign w1c_pend     = wr_en & (address == ADDR_STATUS) & writedata[STATUS_PEND];
    assign wdata_unused = ^writedata[DATA_W-1:CNT_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= '0;
            per_shadow  <= '0;
            duty_shadow <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL:   ctrl_q      <= ctrl_t'(writedata[CTRL_INV:CTRL_EN]);
                ADDR_PERIOD: per_shadow  <= writedata[CNT_W-1:0];
                ADDR_DUTY:   duty_shadow <= writedata[CNT_W-1:0];
                default:     ;
            endcase
        end
    end

    // A period end in the same cycle as a W1C keeps pend set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 1'b0;
        end else if (period_end) begin
            pend <= 1'b1;
        end else if (w1c_pend) begin
            pend <= 1'b0;
        end
    end

    assign irq = pend & ctrl_q.irq_en;

    microcontrolador_pwm_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (ctrl_q.en),
        .inv          (ctrl_q.inv),
        .per_shadow   (per_shadow),
        .duty_shadow  (duty_shadow),
        .cnt          (cnt),
        .pwm_out      (pwm_out),
        .period_end_c (period_end)
    );

    assign status_cnt = STATUS_CNT_W'(cnt);

    always_comb begin
        status_word                 = '0;
        status_word[STATUS_PEND]    = pend;
        status_word[STATUS_RUNNING] = ctrl_q.en;
        status_word[DATA_W-1:STATUS_CNT_LSB] = status_cnt;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata = ctrl_to_word(ctrl_q);
            ADDR_PERIOD: readdata = DATA_W'(per_shadow);
            ADDR_DUTY:   readdata = DATA_W'(duty_shadow);
            ADDR_STATUS: readdata = status_word;
            default:     readdata = '0;
        endcase
    end

endmodule
